variable_delay_line: RTL

Parametrised, runtime-programmable sample delay for the ANC datapath. It generalises the fixed one-cycle 16-bit register into a strobe-qualified circular-buffer delay line. Delay is 0..MAX_DELAY samples, with flush and history tracking. It aligns the reference-microphone path against the secondary path before the adaptive filter, and replaces hand-chained single-sample registers.

---
 rtl/variable_delay_line.sv | 65 ++++++
 1 files changed

// File: rtl/variable_delay_line.sv
// variable_delay_line: strobe-qualified circular-buffer delay of 0..MAX_DELAY samples
// with flush and a fill counter that masks history not yet written.
module variable_delay_line #(
    parameter int WIDTH = 16,
    parameter int MAX_DELAY = 64,
    localparam int DW = $clog2(MAX_DELAY + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in1,
    input  logic                    in_valid,
    input  logic [DW-1:0]           delay,
    input  logic                    flush,
    output logic signed [WIDTH-1:0] out1,
    output logic                    out_valid,
    output logic                    out_primed
);
    localparam int AW = MAX_DELAY > 1 ? $clog2(MAX_DELAY) : 1;

    logic signed [WIDTH-1:0] mem [MAX_DELAY];
    logic [AW-1:0] wr_ptr;
    logic [DW-1:0] fill;
    logic [DW-1:0] d_eff;
    logic [DW:0]   rd_sum;
    logic [AW-1:0] rd;
    logic          primed;
    logic          accept;

    assign accept = in_valid && !flush;
    assign d_eff  = delay > DW'(MAX_DELAY) ? DW'(MAX_DELAY) : delay;
    // Bias by MAX_DELAY so the subtraction never underflows; D=MAX_DELAY lands on wr_ptr.
    assign rd_sum = (DW+1)'(wr_ptr) + (DW+1)'(MAX_DELAY) - (DW+1)'(d_eff);
    assign rd     = AW'(rd_sum >= (DW+1)'(MAX_DELAY) ? rd_sum - (DW+1)'(MAX_DELAY) : rd_sum);
    assign primed = d_eff == '0 || fill >= d_eff;

    // Storage is never reset; the fill counter hides stale entries.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= in1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            fill       <= '0;
            out1       <= '0;
            out_valid  <= 1'b0;
            out_primed <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            fill       <= '0;
            out1       <= '0;
            out_valid  <= 1'b0;
            out_primed <= 1'b0;
        end else if (in_valid) begin
            out1       <= d_eff == '0 ? in1 : primed ? mem[rd] : '0;
            out_primed <= primed;
            out_valid  <= 1'b1;
            wr_ptr     <= wr_ptr == AW'(MAX_DELAY - 1) ? '0 : wr_ptr + 1'b1;
            fill       <= fill == DW'(MAX_DELAY) ? fill : fill + 1'b1;
        end else begin
            out_valid  <= 1'b0;
        end
    end
endmodule
